fp_add_prep: RTL and testbench
==============================

# fp_add_prep

Operand-preparation stage directly upstream of the combinational double-precision FP adder. It accepts add/subtract requests over a valid/ready handshake and buffers them in a small FIFO. It applies the subtract sign flip, flushes denormals and classifies IEEE-754 special operands. Each entry is presented to the adder with a flag that tells the consumer whether to use the adder's result or a precomputed special result.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag carried alongside each request

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all buffered entries
- in_valid  input  1  request present
- in_ready  output  1  stage can accept a request
- in_a  input  64  operand A, IEEE-754 binary64
- in_b  input  64  operand B, IEEE-754 binary64
- in_op  input  1  0 = A+B, 1 = A−B
- in_tag  input  TAG_W  request tag
- out_valid  output  1  head entry present
- out_ready  input  1  consumer accepts head entry
- out_a  output  64  prepared operand A, to adder input A
- out_b  output  64  prepared operand B (sign already flipped for subtract), to adder input B
- out_tag  output  TAG_W  tag of head entry
- out_special  output  1  1 = the consumer ignores the adder and uses out_special_res
- out_special_res  output  64  special-case result, 0 when out_special=0

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both can occur in the same cycle.
- Prep at push time; the results are stored in the entry.
  - b' = {in_b[63]^in_op, in_b[62:0]}.
  - Denormal flush: an operand with exponent 0 becomes a signed zero (mantissa cleared, sign kept).
  - NaN = exp 0x7FF with mantissa ≠0. Inf = exp 0x7FF with mantissa 0. Zero = exp 0.
- Special priority, first match wins:
  1. A or b' is NaN → qNaN 0x7FF8000000000000.
  2. Both are Inf with opposite signs → 0x7FF8000000000000.
  3. A is Inf → A. Otherwise b' is Inf → b'.
  4. Both zero → signed zero: sign = sign(A) & sign(b'). Result is −0 only when both are negative.
  5. A is zero → b'.
  6. b' is zero → A.
  7. Otherwise out_special=0.
- Special entries still carry flushed A/b' on out_a/out_b so the adder sees defined inputs.
- FIFO storage:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - A push only increments count, a pop only decrements it, and a simultaneous push+pop leaves it unchanged.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready. When full, a same-cycle pop does not admit a push.
- out_valid = (count ≠ 0). out_* are driven from the head entry's storage.
- flush clears count, wr_ptr and rd_ptr next edge and overrides any same-cycle push or pop. A push that coincides with flush is dropped.

## Timing
- Reset (async assert, sync release): count=0 and pointers=0, so out_valid=0 and in_ready=1. out_a, out_b, out_tag, out_special and out_special_res are all 0.
- Latency: a request pushed at edge N appears on out_* with out_valid=1 after edge N, i.e. it is consumable in cycle N+1.
- Throughput: one request per cycle while not full and the consumer is ready.
- A head entry is held stable, with out_* unchanged, while out_valid && !out_ready.
- Reset mid-operation discards all entries; no partial state survives.

## Configuration
- FP_ADD_PREP_SUB_EN:
  - Defined: in_op is honoured (sign flip on B, subtract semantics in the special cases).
  - Undefined: in_op is ignored, b' = flushed in_b, and the stage performs addition only.

## Test plan
- Add 1.0+2.0, op=0: in_a=0x3FF0000000000000, in_b=0x4000000000000000, tag=3 → next cycle out_valid=1, out_b=0x4000000000000000, out_special=0, out_tag=3.
- Sub 1.0−1.0, op=1: → out_b=0xBFF0000000000000, out_special=0. With FP_ADD_PREP_SUB_EN undefined → out_b=0x3FF0000000000000.
- Specials:
  - +Inf + −Inf → out_special=1, res=0x7FF8000000000000.
  - NaN 0x7FF0000000000001 + 1.0 → same qNaN.
  - −0 + −0 → res=0x8000000000000000.
  - Denormal 0x0000000000000001 + 2.0 → res=0x4000000000000000.
- Backpressure, DEPTH=2: push 3 requests with out_ready=0 → in_ready drops after the 2nd push, the 3rd is held. Raise out_ready → tags pop in order, and in_ready rises the cycle after the first pop.
- Wrap and simultaneous events: stream 10 requests with out_ready=1 → tags emerge in order one per cycle, count stays ≤1, and the pointers wrap correctly.
- Flush and reset: fill the FIFO, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1, with nothing emitted. Assert rst_n=0 mid-stream → outputs go to 0 immediately (asynchronous).

Source files
------------

// File: rtl/fp_add_prep_if.sv
// Request/response bundle between a producer, the fp_add_prep stage and the adder consumer.
// slave = the preparation stage; master = the surrounding environment.
interface fp_add_prep_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_a;
   logic [63:0]      in_b;
   logic             in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_a;
   logic [63:0]      out_b;
   logic [TAG_W-1:0] out_tag;
   logic             out_special;
   logic [63:0]      out_special_res;

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_tag, out_special, out_special_res
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_a, out_b, out_tag, out_special, out_special_res
   );
endinterface

// File: rtl/fp_add_prep.sv
// Operand-preparation FIFO ahead of the binary64 adder: sign flip, denormal flush, special classification.
// Optional feature macro FP_ADD_PREP_SUB_EN: when defined, in_op selects subtract (sign flip on B).
module fp_add_prep #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   fp_add_prep_if.slave  bus
);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;

   typedef struct packed {
      logic [63:0]      a;
      logic [63:0]      b;
      logic [TAG_W-1:0] tag;
      logic             special;
      logic [63:0]      res;
   } entry_t;

   logic          op_eff;
   logic [63:0]   b_flip;
   logic [63:0]   a_flush;
   logic [63:0]   b_flush;
   logic          a_zero;
   logic          b_zero;
   logic          a_inf;
   logic          b_inf;
   logic          a_nan;
   logic          b_nan;
   logic          prep_special;
   logic [63:0]   prep_res;
   entry_t        prep_entry;
   entry_t        head_entry;
   entry_t        mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          ready;
   logic          valid;
   logic          push;
   logic          pop;

`ifdef FP_ADD_PREP_SUB_EN
   assign op_eff = bus.in_op;
`else
   assign op_eff = bus.in_op & 1'b0;
`endif

   assign b_flip = {bus.in_b[63] ^ op_eff, bus.in_b[62:0]};

   always_comb begin
      a_zero  = (bus.in_a[62:52] == 11'd0);
      b_zero  = (b_flip[62:52] == 11'd0);
      a_inf   = (bus.in_a[62:52] == 11'h7FF) && (bus.in_a[51:0] == 52'd0);
      b_inf   = (b_flip[62:52] == 11'h7FF) && (b_flip[51:0] == 52'd0);
      a_nan   = (bus.in_a[62:52] == 11'h7FF) && (bus.in_a[51:0] != 52'd0);
      b_nan   = (b_flip[62:52] == 11'h7FF) && (b_flip[51:0] != 52'd0);
      a_flush = a_zero ? {bus.in_a[63], 63'd0} : bus.in_a;
      b_flush = b_zero ? {b_flip[63], 63'd0} : b_flip;
   end

   // First matching rule wins; zero detection uses the flushed view so denormals count as zero.
   always_comb begin
      prep_special = 1'b1;
      prep_res     = QNAN;
      if (a_nan || b_nan) begin
         prep_res = QNAN;
      end else if (a_inf && b_inf && (a_flush[63] != b_flush[63])) begin
         prep_res = QNAN;
      end else if (a_inf) begin
         prep_res = a_flush;
      end else if (b_inf) begin
         prep_res = b_flush;
      end else if (a_zero && b_zero) begin
         prep_res = {a_flush[63] & b_flush[63], 63'd0};
      end else if (a_zero) begin
         prep_res = b_flush;
      end else if (b_zero) begin
         prep_res = a_flush;
      end else begin
         prep_special = 1'b0;
         prep_res     = 64'd0;
      end
   end

   always_comb begin
      prep_entry         = '0;
      prep_entry.a       = a_flush;
      prep_entry.b       = b_flush;
      prep_entry.tag     = bus.in_tag;
      prep_entry.special = prep_special;
      prep_entry.res     = prep_res;
   end

   assign ready = (count_reg < DEPTH_C);
   assign valid = (count_reg != '0);
   assign push  = bus.in_valid && ready && !flush;
   assign pop   = valid && bus.out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= prep_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Outputs are gated by occupancy so an empty or reset stage presents all zeros.
   assign head_entry          = mem_reg[rd_ptr_reg];
   assign bus.in_ready        = ready;
   assign bus.out_valid       = valid;
   assign bus.out_a           = valid ? head_entry.a       : 64'd0;
   assign bus.out_b           = valid ? head_entry.b       : 64'd0;
   assign bus.out_tag         = valid ? head_entry.tag     : '0;
   assign bus.out_special     = valid ? head_entry.special : 1'b0;
   assign bus.out_special_res = valid ? head_entry.res     : 64'd0;
endmodule

// File: tb/tb_fp_add_prep.sv
// Randomised and directed bench for fp_add_prep against a queue-based reference model.
// Follows FP_ADD_PREP_SUB_EN so expectations match the build under test.
module tb_fp_add_prep;
   localparam int          DEPTH = 2;
   localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
`ifdef FP_ADD_PREP_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        sp;
      logic [63:0] res;
   } prep_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      logic        sp;
      logic [63:0] res;
   } entry_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks;
   int   errors;
   entry_t q[$];

   fp_add_prep_if #(.TAG_W(4)) bus ();

   fp_add_prep #(.DEPTH(DEPTH), .TAG_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: classify each operand from its fields, then apply the rule list in order.
   function automatic prep_t ref_prep(input logic [63:0] a, input logic [63:0] b_in, input logic op);
      prep_t r;
      logic [63:0] b;
      bit za, zb, ia, ib, na, nb;
      b = b_in;
      if (SUB_EN && op) b[63] = ~b[63];
      za = (a[62:52] == 0);
      zb = (b[62:52] == 0);
      ia = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
      ib = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
      na = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      nb = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      r.a   = za ? {a[63], 63'd0} : a;
      r.b   = zb ? {b[63], 63'd0} : b;
      r.sp  = 1'b1;
      r.res = QNAN;
      if (na || nb)                        r.res = QNAN;
      else if (ia && ib && a[63] != b[63]) r.res = QNAN;
      else if (ia)                         r.res = r.a;
      else if (ib)                         r.res = r.b;
      else if (za && zb)                   r.res = {a[63] & b[63], 63'd0};
      else if (za)                         r.res = r.b;
      else if (zb)                         r.res = r.a;
      else begin
         r.sp  = 1'b0;
         r.res = 64'd0;
      end
      return r;
   endfunction

   function automatic logic [198:0] dut_view();
      return {bus.out_valid, bus.in_ready, bus.out_a, bus.out_b, bus.out_tag,
              bus.out_special, bus.out_special_res};
   endfunction

   function automatic logic [198:0] model_view();
      if (q.size() == 0) return {1'b0, 1'b1, 197'd0};
      return {1'b1, (q.size() < DEPTH), q[0].a, q[0].b, q[0].tag, q[0].sp, q[0].res};
   endfunction

   function automatic logic [63:0] rand_fp();
      logic [63:0] r;
      logic [10:0] e;
      r = {$urandom, $urandom};
      e = 11'($urandom_range(1, 2046));
      case ($urandom_range(0, 7))
         0:       return {r[63], 63'd0};
         1:       return {r[63], 11'd0, r[51:0]};
         2:       return {r[63], 11'h7FF, 52'd0};
         3:       return {r[63], 11'h7FF, r[51:1], 1'b1};
         default: return {r[63], e, r[51:0]};
      endcase
   endfunction

   // Drives one cycle from a negedge, updates the model at the posedge, returns at the next negedge.
   task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b, input logic op,
                       input logic [3:0] tag, input logic rdy, input logic fl);
      bit    do_push;
      bit    do_pop;
      prep_t p;
      entry_t e;
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.in_tag    = tag;
      bus.out_ready = rdy;
      flush         = fl;
      do_pop  = (q.size() != 0) && rdy && !fl;
      do_push = v && (q.size() < DEPTH) && !fl;
      @(posedge clk);
      if (fl) begin
         $display("flush: %0d entries dropped", q.size());
         q.delete();
      end else begin
         if (do_pop) begin
            $display("pop  tag=%0d sp=%0b res=%h", q[0].tag, q[0].sp, q[0].res);
            void'(q.pop_front());
         end
         if (do_push) begin
            p = ref_prep(a, b, op);
            e = '{a: p.a, b: p.b, tag: tag, sp: p.sp, res: p.res};
            q.push_back(e);
            $display("push tag=%0d a=%h b=%h op=%0b", tag, a, b, op);
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 64'd0;
      bus.in_b      = 64'd0;
      bus.in_op     = 1'b0;
      bus.in_tag    = 4'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_view() !== {1'b0, 1'b1, 197'd0}) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", dut_view(), {1'b0, 1'b1, 197'd0});
      end
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (dut_view() !== {1'b0, 1'b1, 197'd0}) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", dut_view(), {1'b0, 1'b1, 197'd0});
      end
   endtask

   task automatic test_specials();
      logic [63:0] va   [8] = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000,
                                64'h7FF0000000000001, 64'h8000000000000000, 64'h0000000000000001,
                                64'h7FF0000000000000, 64'h8000000000000000};
      logic [63:0] vb   [8] = '{64'h4000000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000,
                                64'h3FF0000000000000, 64'h8000000000000000, 64'h4000000000000000,
                                64'h7FF0000000000000, 64'h0000000000000000};
      logic        vop  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [63:0] ea   [8] = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000,
                                64'h7FF0000000000001, 64'h8000000000000000, 64'h0000000000000000,
                                64'h7FF0000000000000, 64'h8000000000000000};
      logic [63:0] eb   [8] = '{64'h4000000000000000,
                                SUB_EN ? 64'hBFF0000000000000 : 64'h3FF0000000000000,
                                64'hFFF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000,
                                64'h4000000000000000,
                                SUB_EN ? 64'hFFF0000000000000 : 64'h7FF0000000000000,
                                64'h0000000000000000};
      logic        esp  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [63:0] eres [8] = '{64'd0, 64'd0, QNAN, QNAN, 64'h8000000000000000,
                                64'h4000000000000000,
                                SUB_EN ? QNAN : 64'h7FF0000000000000, 64'd0};
      for (int i = 0; i < 8; i++) begin
         step(1, va[i], vb[i], vop[i], 4'(i + 3), 0, 0);
         checks++;
         if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_tag, bus.out_special, bus.out_special_res}
             !== {1'b1, ea[i], eb[i], 4'(i + 3), esp[i], eres[i]}) begin
            errors++;
            $display("FAIL special_vec%0d: got v=%0b a=%h b=%h tag=%0d sp=%0b res=%h want a=%h b=%h tag=%0d sp=%0b res=%h",
                     i, bus.out_valid, bus.out_a, bus.out_b, bus.out_tag, bus.out_special,
                     bus.out_special_res, ea[i], eb[i], i + 3, esp[i], eres[i]);
         end
         step(0, 0, 0, 0, 0, 1, 0);
         checks++;
         if (dut_view() !== model_view()) begin
            errors++;
            $display("FAIL special_pop%0d: got %h want %h", i, dut_view(), model_view());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] want_tag [6] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0};
      logic       want_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       want_vld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       drv_v    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] drv_tag  [6] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0};
      logic       drv_rdy  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(drv_v[i], rand_fp(), rand_fp(), 1'($urandom), drv_tag[i], drv_rdy[i], 0);
         checks++;
         if ({bus.out_valid, bus.in_ready, bus.out_tag} !== {want_vld[i], want_rdy[i], want_tag[i]}) begin
            errors++;
            $display("FAIL backpressure_step%0d: got v=%0b rdy=%0b tag=%0d want v=%0b rdy=%0b tag=%0d",
                     i, bus.out_valid, bus.in_ready, bus.out_tag, want_vld[i], want_rdy[i], want_tag[i]);
         end
         checks++;
         if (dut_view() !== model_view()) begin
            errors++;
            $display("FAIL backpressure_view%0d: got %h want %h", i, dut_view(), model_view());
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         step(1, rand_fp(), rand_fp(), 1'($urandom), 4'(i), 1, 0);
         checks++;
         if ({bus.out_valid, bus.in_ready, bus.out_tag} !== {1'b1, 1'b1, 4'(i)}) begin
            errors++;
            $display("FAIL stream%0d: got v=%0b rdy=%0b tag=%0d want v=1 rdy=1 tag=%0d",
                     i, bus.out_valid, bus.in_ready, bus.out_tag, i);
         end
         checks++;
         if (dut_view() !== model_view()) begin
            errors++;
            $display("FAIL stream_view%0d: got %h want %h", i, dut_view(), model_view());
         end
      end
      step(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (dut_view() !== model_view()) begin
         errors++;
         $display("FAIL stream_drain: got %h want %h", dut_view(), model_view());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 3) != 0), rand_fp(), rand_fp(), 1'($urandom), 4'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
         checks++;
         if (dut_view() !== model_view()) begin
            errors++;
            $display("FAIL random%0d: got %h want %h", i, dut_view(), model_view());
         end
      end
      repeat (2) step(0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_flush();
      step(1, rand_fp(), rand_fp(), 0, 4'd7, 0, 0);
      step(1, rand_fp(), rand_fp(), 0, 4'd8, 0, 0);
      step(1, rand_fp(), rand_fp(), 0, 4'd9, 1, 1);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL flush_clear: got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      step(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (dut_view() !== {1'b0, 1'b1, 197'd0}) begin
         errors++;
         $display("FAIL flush_nothing_emitted: got %h want %h", dut_view(), {1'b0, 1'b1, 197'd0});
      end
   endtask

   task automatic test_async_reset();
      step(1, 64'h3FF0000000000000, 64'h4000000000000000, 0, 4'd5, 0, 0);
      step(1, 64'h7FF0000000000000, 64'h3FF0000000000000, 0, 4'd6, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_view() !== {1'b0, 1'b1, 197'd0}) begin
         errors++;
         $display("FAIL async_reset: got %h want %h", dut_view(), {1'b0, 1'b1, 197'd0});
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (dut_view() !== model_view()) begin
         errors++;
         $display("FAIL after_reset: got %h want %h", dut_view(), model_view());
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_specials();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
